// File: rtl/ext_pkg.sv
// Shared types and helpers for the immediate/shift-amount extension stage.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_HIGH = 2'b10,
    EXT_BOFS = 2'b11
  } ext_mode_t;

  localparam int EXT_MAX_W = 64;

  // Width-agnostic reference of the extension, usable in constant expressions.
  function automatic logic [EXT_MAX_W-1:0] ext_apply(
    input logic [EXT_MAX_W-1:0] data,
    input ext_mode_t            mode,
    input int                   in_w,
    input int                   out_w
  );
    logic [EXT_MAX_W-1:0] mask_in;
    logic [EXT_MAX_W-1:0] sx;
    logic [EXT_MAX_W-1:0] r;
    mask_in = (64'd1 << in_w) - 64'd1;
    sx      = data & mask_in;
    if (((data >> (in_w - 1)) & 64'd1) != 64'd0) sx = sx | ~mask_in;
    case (mode)
      EXT_ZERO: r = data & mask_in;
      EXT_SIGN: r = sx;
      EXT_HIGH: r = (data & mask_in) << (out_w - in_w);
      default:  r = sx << 2;
    endcase
    return r & ((64'd1 << out_w) - 64'd1);
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extender: maps an IN_W-bit field and a mode to an OUT_W-bit result.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] result
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] zx;
  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] hx;

  assign zx = {{PAD{1'b0}}, data};
  assign sx = {{PAD{data[IN_W-1]}}, data};
  assign hx = {data, {PAD{1'b0}}};

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    result = zx;
    case (mode)
      EXT_ZERO: result = zx;
      EXT_SIGN: result = sx;
      EXT_HIGH: result = hx;
      EXT_BOFS: result = sx << 2;
      default:  result = zx;
    endcase
  end

endmodule

// File: rtl/ext_stage.sv
// Registered extension stage with valid/ready handshake and synchronous flush.
// Define EXT_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module ext_stage
  import ext_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] ext_data;
  logic             in_fire;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .data   (in_data),
    .mode   (ext_mode_t'(in_mode)),
    .result (ext_data)
  );

  assign in_fire = in_valid && in_ready;

`ifdef EXT_SKID_EN
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;

  // Ready comes straight from the skid flop; rst only masks it.
  assign in_ready = !rst && !skid_valid;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the skid payload is not reset; skid_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_tag    <= skid_tag;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_data <= ext_data;
          out_tag  <= in_tag;
        end
      end
    end else if (in_fire) begin
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_data  <= ext_data;
      out_tag   <= in_tag;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ext_stage.sv
// Directed self-checking bench for ext_stage (default and 16-bit-field instances).
module tb_ext_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_in_data;
  logic [1:0]  w_in_mode;
  logic [4:0]  w_in_tag;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_data;
  logic [4:0]  w_out_tag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ext_stage #(.IN_W(5), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_tag(w_out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one field and wait (bounded) until it is accepted.
  task automatic send(input logic [4:0] d, input logic [1:0] m, input logic [4:0] t);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = in_ready;
      step();
    end
    if (!done) check("send_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] ref_ext(input logic [4:0] d, input logic [1:0] m);
    logic signed [31:0] s;
    s = 32'($signed(d));
    case (m)
      2'b00:   return {27'd0, d};
      2'b01:   return s;
      2'b10:   return {d, 27'd0};
      default: return s * 4;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d [16];
    logic [4:0]  exp_t [16];
    int  next_tag, got, stall_left, stall_cyc;
    bit  stall_done, in_f;
    logic exp_ready_at_stall;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 5'h0A; in_mode = 2'b00; in_tag = 5'd7;
    w_in_valid = 1'b0; w_in_data = '0; w_in_mode = '0; w_in_tag = '0; w_out_ready = 1'b1;

    // Reset held for three cycles with a field offered throughout.
    repeat (3) step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_tag", {59'd0, out_tag}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    in_data = 5'h1F; in_tag = 5'd1;
    #1;
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_data", {32'd0, out_data}, 64'h0000001F);
    check("first_tag", {59'd0, out_tag}, 64'd1);
    step();
    check("no_reset_capture", {63'd0, out_valid}, 64'd0);

    // One field, every mode.
    send(5'h10, 2'b00, 5'd0);
    check("mode_zero", {32'd0, out_data}, 64'h00000010);
    send(5'h10, 2'b01, 5'd1);
    check("mode_sign", {32'd0, out_data}, 64'hFFFFFFF0);
    send(5'h10, 2'b10, 5'd2);
    check("mode_high", {32'd0, out_data}, 64'h80000000);
    send(5'h10, 2'b11, 5'd3);
    check("mode_bofs", {32'd0, out_data}, 64'hFFFFFFC0);
    check("mode_bofs_tag", {59'd0, out_tag}, 64'd3);
    step();

    // Back-pressure: tags 1..6, downstream stalls 3 cycles once tag 2 is presented.
`ifdef EXT_SKID_EN
    exp_ready_at_stall = 1'b1;
`else
    exp_ready_at_stall = 1'b0;
`endif
    next_tag = 1; got = 0; stall_left = 0; stall_done = 0; stall_cyc = -10;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (!stall_done && out_valid && out_tag == 5'd2) begin
        stall_left = 3; stall_done = 1; stall_cyc = cyc;
      end
      out_ready = (stall_left == 0);
      in_valid  = (next_tag <= 6);
      in_data   = 5'(next_tag);
      in_tag    = 5'(next_tag);
      in_mode   = 2'b00;
      #1;
      if (cyc == stall_cyc) check("bp_ready_at_stall", {63'd0, in_ready}, {63'd0, exp_ready_at_stall});
      if (cyc == stall_cyc + 1) check("bp_ready_fall", {63'd0, in_ready}, 64'd0);
      in_f = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got++;
        check("bp_tag", {59'd0, out_tag}, 64'(got));
        check("bp_data", {32'd0, out_data}, 64'(got));
      end
      step();
      if (in_f) next_tag++;
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd6);
    check("bp_stalled", {63'd0, stall_done}, 64'd1);
    step();

    // Full throughput: 16 back-to-back transfers.
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 16) begin
        in_valid = 1'b1;
        in_data  = 5'(cyc * 7 + 3);
        in_mode  = 2'(cyc);
        in_tag   = 5'(cyc);
        exp_d[cyc] = ref_ext(in_data, in_mode);
        exp_t[cyc] = in_tag;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 16) check("thru_ready", {63'd0, in_ready}, 64'd1);
      if (cyc >= 1 && cyc <= 16) begin
        check("thru_valid", {63'd0, out_valid}, 64'd1);
        check("thru_data", {32'd0, out_data}, {32'd0, exp_d[cyc-1]});
        check("thru_tag", {59'd0, out_tag}, {59'd0, exp_t[cyc-1]});
      end
      step();
    end
    check("thru_drained", {63'd0, out_valid}, 64'd0);

    // Flush with entries held and a same-cycle input.
    out_ready = 1'b0;
    send(5'h03, 2'b00, 5'd10);
    check("fl_held_valid", {63'd0, out_valid}, 64'd1);
    check("fl_held_tag", {59'd0, out_tag}, 64'd10);
`ifdef EXT_SKID_EN
    send(5'h04, 2'b00, 5'd11);
    check("fl_skid_full", {63'd0, in_ready}, 64'd0);
    check("fl_out_stable", {59'd0, out_tag}, 64'd10);
`endif
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 5'h05; in_mode = 2'b00; in_tag = 5'd12;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("fl_stays_empty", {63'd0, out_valid}, 64'd0);
    end
    send(5'h06, 2'b01, 5'd13);
    check("fl_after_valid", {63'd0, out_valid}, 64'd1);
    check("fl_after_data", {32'd0, out_data}, 64'h00000006);
    check("fl_after_tag", {59'd0, out_tag}, 64'd13);
    step();

    // 16-bit field instance.
    w_in_data = 16'h8001; w_in_tag = 5'd9;
    for (int m = 0; m < 4; m++) begin
      w_in_valid = 1'b1;
      w_in_mode  = 2'(m);
      #1;
      check("w_ready", {63'd0, w_in_ready}, 64'd1);
      step();
      w_in_valid = 1'b0;
      check("w_valid", {63'd0, w_out_valid}, 64'd1);
      case (m)
        0: check("w_zero", {32'd0, w_out_data}, 64'h00008001);
        1: check("w_sign", {32'd0, w_out_data}, 64'hFFFF8001);
        2: check("w_high", {32'd0, w_out_data}, 64'h80010000);
        default: check("w_bofs", {32'd0, w_out_data}, 64'hFFFE0004);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
